// File: rtl/reaction_session_ctrl_pkg.sv
// reaction_session_ctrl_pkg: shared types and widths for the reaction-timer session controller
package reaction_pkg;
  localparam int TIME_W = 10;
  localparam int RAND_W = 13;
  localparam int SUM_W = 13;
  localparam logic [TIME_W-1:0] TIME_NONE = 10'h3FF;
  typedef enum logic [2:0] {ROUND, SEND, DIV, SUMMARY, DONE} state_e;
  typedef enum logic [1:0] {CODE_OK, CODE_CHEAT, CODE_SLOW, CODE_SUMMARY} lcd_code_e;
endpackage

// File: rtl/reaction_session_ctrl_if.sv
// reaction_session_ctrl_if: timer, LCD and status signals of the session controller
interface reaction_session_ctrl_if;
  import reaction_pkg::*;
  logic TimerUpdate;
  logic [TIME_W-1:0] TimerTime;
  logic TimerWait;
  logic TimerCheat;
  logic TimerSlow;
  logic Clear;
  logic LcdAck;
  logic [RAND_W-1:0] RandomValue;
  logic LcdBusy;
  logic LcdReq;
  logic [1:0] LcdCode;
  logic [TIME_W-1:0] LcdData;
  logic [2:0] RoundNum;
  logic [TIME_W-1:0] BestTime;
  logic [TIME_W-1:0] AvgTime;
  logic [2:0] ErrCount;
  logic Overrun;
  logic SessionDone;
  modport master (
    input TimerUpdate, TimerTime, TimerWait, TimerCheat, TimerSlow, Clear, LcdAck,
    output RandomValue, LcdBusy, LcdReq, LcdCode, LcdData, RoundNum, BestTime, AvgTime,
    ErrCount, Overrun, SessionDone
  );
  modport slave (
    output TimerUpdate, TimerTime, TimerWait, TimerCheat, TimerSlow, Clear, LcdAck,
    input RandomValue, LcdBusy, LcdReq, LcdCode, LcdData, RoundNum, BestTime, AvgTime,
    ErrCount, Overrun, SessionDone
  );
endinterface

// File: rtl/reaction_session_ctrl_div.sv
// session_avg_div: restoring divider, one quotient bit per cycle, 13-cycle latency
module session_avg_div
  import reaction_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [2:0]       divisor_i,
  output logic [SUM_W-1:0] quotient_o,
  output logic             done_o
);
  logic [SUM_W-1:0] quo_q;
  logic [2:0] rem_q, div_q;
  logic [3:0] cnt_q, trial;
  logic fits;
  // remainder stays below the 3-bit divisor, so 3 bits plus the shifted-in bit suffice
  assign trial = {rem_q, quo_q[SUM_W-1]};
  assign fits = trial >= {1'b0, div_q};
  assign quotient_o = quo_q;
  always_ff @(posedge Clk)
    if (Rst) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        quo_q <= dividend_i;
        rem_q <= '0;
        div_q <= divisor_i;
        cnt_q <= 4'd13;
      end else if (cnt_q != 4'd0) begin
        rem_q <= fits ? 3'(trial - {1'b0, div_q}) : trial[2:0];
        quo_q <= {quo_q[SUM_W-2:0], fits};
        cnt_q <= cnt_q - 4'd1;
        done_o <= cnt_q == 4'd1;
      end
    end
endmodule

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: round gating, result classification and LCD reporting for a fixed-length session
module reaction_session_ctrl
  import reaction_pkg::*;
#(
  parameter int NUM_ROUNDS = 5,
  parameter logic [RAND_W-1:0] LFSR_SEED = 13'h1ACE
) (
  input logic Clk,
  input logic Rst,
  reaction_session_ctrl_if.master bus
);
  state_e state_q;
  logic [RAND_W-1:0] lfsr_q;
  logic [2:0] round_q, cnt_q, err_q;
  logic [SUM_W-1:0] sum_q, quo;
  logic [TIME_W-1:0] best_q, avg_q, data_q, avg_d;
  logic [1:0] code_q;
  logic overrun_q, req_q, start_q, div_done, last_round;
  session_avg_div u_div (
    .Clk(Clk), .Rst(Rst), .start_i(start_q), .dividend_i(sum_q), .divisor_i(cnt_q),
    .quotient_o(quo), .done_o(div_done)
  );
  assign last_round = round_q >= 3'(NUM_ROUNDS);
  assign avg_d = (cnt_q == 3'd0 || |quo[SUM_W-1:TIME_W]) ? TIME_NONE : quo[TIME_W-1:0];
  always_ff @(posedge Clk)
    if (Rst) begin
      state_q <= ROUND;
      lfsr_q <= LFSR_SEED;
      round_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      best_q <= TIME_NONE;
      avg_q <= '0;
      err_q <= '0;
      overrun_q <= 1'b0;
      req_q <= 1'b0;
      code_q <= '0;
      data_q <= '0;
      start_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[RAND_W-2:0], lfsr_q[12] ^ lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[7]};
      start_q <= 1'b0;
      case (state_q)
        ROUND: if (bus.TimerUpdate && !bus.TimerWait) begin
          round_q <= round_q + 3'd1;
          req_q <= 1'b1;
          state_q <= SEND;
          if (bus.TimerCheat || bus.TimerSlow) begin
            err_q <= err_q + 3'd1;
            code_q <= bus.TimerCheat ? CODE_CHEAT : CODE_SLOW;
            data_q <= '0;
          end else begin
            sum_q <= sum_q + SUM_W'(bus.TimerTime);
            cnt_q <= cnt_q + 3'd1;
            best_q <= bus.TimerTime < best_q ? bus.TimerTime : best_q;
            code_q <= CODE_OK;
            data_q <= bus.TimerTime;
          end
        end
        SEND: if (bus.LcdAck) begin
          req_q <= 1'b0;
          state_q <= last_round ? DIV : ROUND;
          start_q <= last_round && cnt_q != 3'd0;
        end
        // with no OK rounds the divider is never started and DIV exits at once
        DIV: if (cnt_q == 3'd0 || div_done) begin
          avg_q <= avg_d;
          data_q <= avg_d;
          code_q <= CODE_SUMMARY;
          req_q <= 1'b1;
          state_q <= SUMMARY;
        end
        SUMMARY: if (bus.LcdAck) begin
          req_q <= 1'b0;
          state_q <= DONE;
        end
        DONE: if (bus.Clear) begin
          round_q <= '0;
          sum_q <= '0;
          cnt_q <= '0;
          err_q <= '0;
          overrun_q <= 1'b0;
          avg_q <= '0;
          best_q <= TIME_NONE;
          state_q <= ROUND;
        end
        default: state_q <= ROUND;
      endcase
      if (bus.TimerUpdate && state_q != ROUND) overrun_q <= 1'b1;
    end
  assign bus.RandomValue = lfsr_q;
  assign bus.LcdBusy = state_q != ROUND;
  assign bus.LcdReq = req_q;
  assign bus.LcdCode = code_q;
  assign bus.LcdData = data_q;
  assign bus.RoundNum = round_q;
  assign bus.BestTime = best_q;
  assign bus.AvgTime = avg_q;
  assign bus.ErrCount = err_q;
  assign bus.Overrun = overrun_q;
  assign bus.SessionDone = state_q == DONE;
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl: directed session scenarios with hand-computed expectations
module tb_reaction_session_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  reaction_session_ctrl_if bus();
  reaction_session_ctrl #(.NUM_ROUNDS(3)) dut (.Clk(clk), .Rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset();
    check("rst_rand", bus.RandomValue, 13'h1ACE);
    check("rst_best", 13'(bus.BestTime), 13'h3FF);
    check("rst_req", 13'(bus.LcdReq), 0);
    check("rst_busy", 13'(bus.LcdBusy), 0);
    check("rst_code", 13'(bus.LcdCode), 0);
    check("rst_data", 13'(bus.LcdData), 0);
    check("rst_round", 13'(bus.RoundNum), 0);
    check("rst_avg", 13'(bus.AvgTime), 0);
    check("rst_err", 13'(bus.ErrCount), 0);
    check("rst_ovr", 13'(bus.Overrun), 0);
    check("rst_done", 13'(bus.SessionDone), 0);
  endtask
  task automatic play(input logic c, input logic s, input logic [9:0] t,
                      input logic [1:0] ecode, input logic [9:0] edata, input logic [2:0] eround);
    bus.TimerUpdate = 1'b1;
    bus.TimerCheat = c;
    bus.TimerSlow = s;
    bus.TimerTime = t;
    tick();
    bus.TimerUpdate = 1'b0;
    check("msg_req", 13'(bus.LcdReq), 1);
    check("msg_code", 13'(bus.LcdCode), 13'(ecode));
    check("msg_data", 13'(bus.LcdData), 13'(edata));
    check("msg_round", 13'(bus.RoundNum), 13'(eround));
    check("msg_busy", 13'(bus.LcdBusy), 1);
    bus.LcdAck = 1'b1;
    tick();
    bus.LcdAck = 1'b0;
    check("msg_req_drop", 13'(bus.LcdReq), 0);
  endtask
  task automatic finish_session(input logic [9:0] eavg, input logic [9:0] ebest,
                                input logic [2:0] eerr, input int elat);
    int n = 0;
    while (!bus.LcdReq && n < 40) begin
      tick();
      n++;
    end
    check("div_lat", 13'(n), 13'(elat));
    check("sum_code", 13'(bus.LcdCode), 3);
    check("sum_data", 13'(bus.LcdData), 13'(eavg));
    bus.LcdAck = 1'b1;
    tick();
    bus.LcdAck = 1'b0;
    check("done", 13'(bus.SessionDone), 1);
    check("done_req", 13'(bus.LcdReq), 0);
    check("done_busy", 13'(bus.LcdBusy), 1);
    check("done_avg", 13'(bus.AvgTime), 13'(eavg));
    check("done_best", 13'(bus.BestTime), 13'(ebest));
    check("done_err", 13'(bus.ErrCount), 13'(eerr));
  endtask
  task automatic clear_session();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    check("clr_done", 13'(bus.SessionDone), 0);
    check("clr_round", 13'(bus.RoundNum), 0);
    check("clr_best", 13'(bus.BestTime), 13'h3FF);
    check("clr_avg", 13'(bus.AvgTime), 0);
    check("clr_err", 13'(bus.ErrCount), 0);
    check("clr_busy", 13'(bus.LcdBusy), 0);
  endtask
  initial begin
    logic seen_zero = 1'b0;
    bus.TimerUpdate = 1'b0;
    bus.TimerTime = '0;
    bus.TimerWait = 1'b0;
    bus.TimerCheat = 1'b0;
    bus.TimerSlow = 1'b0;
    bus.Clear = 1'b0;
    bus.LcdAck = 1'b0;
    tick();
    tick();
    check_reset();
    rst = 1'b0;
    for (int i = 0; i < 8191; i++) begin
      tick();
      if (i == 0) check("lfsr_step1", bus.RandomValue, 13'h159D);
      if (bus.RandomValue == 13'h0) seen_zero = 1'b1;
    end
    check("lfsr_period", bus.RandomValue, 13'h1ACE);
    check("lfsr_nonzero", 13'(seen_zero), 0);
    bus.Clear = 1'b1;
    bus.LcdAck = 1'b1;
    tick();
    bus.Clear = 1'b0;
    bus.LcdAck = 1'b0;
    check("clr_ignored_done", 13'(bus.SessionDone), 0);
    check("clr_ignored_busy", 13'(bus.LcdBusy), 0);
    bus.TimerUpdate = 1'b1;
    bus.TimerWait = 1'b1;
    tick();
    bus.TimerUpdate = 1'b0;
    bus.TimerWait = 1'b0;
    check("wait_req", 13'(bus.LcdReq), 0);
    check("wait_round", 13'(bus.RoundNum), 0);
    check("wait_ovr", 13'(bus.Overrun), 0);
    play(1'b0, 1'b0, 10'd250, 2'd0, 10'd250, 3'd1);
    play(1'b0, 1'b0, 10'd180, 2'd0, 10'd180, 3'd2);
    play(1'b0, 1'b0, 10'd310, 2'd0, 10'd310, 3'd3);
    finish_session(10'd246, 10'd180, 3'd0, 15);
    clear_session();
    play(1'b1, 1'b0, 10'd77, 2'd1, 10'd0, 3'd1);
    play(1'b0, 1'b1, 10'd600, 2'd2, 10'd0, 3'd2);
    play(1'b0, 1'b0, 10'd400, 2'd0, 10'd400, 3'd3);
    finish_session(10'd400, 10'd400, 3'd2, 15);
    clear_session();
    play(1'b1, 1'b1, 10'd50, 2'd1, 10'd0, 3'd1);
    play(1'b1, 1'b0, 10'd60, 2'd1, 10'd0, 3'd2);
    play(1'b1, 1'b0, 10'd70, 2'd1, 10'd0, 3'd3);
    finish_session(10'h3FF, 10'h3FF, 3'd3, 1);
    clear_session();
    bus.TimerUpdate = 1'b1;
    bus.TimerCheat = 1'b0;
    bus.TimerSlow = 1'b0;
    bus.TimerTime = 10'd100;
    tick();
    bus.TimerUpdate = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.TimerUpdate = i == 10;
      bus.TimerTime = i == 10 ? 10'd5 : 10'd100;
      tick();
      bus.TimerUpdate = 1'b0;
      check("hold_req", 13'(bus.LcdReq), 1);
      check("hold_data", 13'(bus.LcdData), 100);
      check("hold_busy", 13'(bus.LcdBusy), 1);
    end
    check("ovr_set", 13'(bus.Overrun), 1);
    check("ovr_round", 13'(bus.RoundNum), 1);
    check("ovr_best", 13'(bus.BestTime), 100);
    check("ovr_err", 13'(bus.ErrCount), 0);
    bus.LcdAck = 1'b1;
    tick();
    bus.LcdAck = 1'b0;
    play(1'b0, 1'b0, 10'd200, 2'd0, 10'd200, 3'd2);
    play(1'b0, 1'b0, 10'd300, 2'd0, 10'd300, 3'd3);
    for (int i = 0; i < 5; i++) tick();
    check("div_busy", 13'(bus.LcdBusy), 1);
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    play(1'b0, 1'b0, 10'd7, 2'd0, 10'd7, 3'd1);
    play(1'b0, 1'b0, 10'd8, 2'd0, 10'd8, 3'd2);
    play(1'b0, 1'b0, 10'd9, 2'd0, 10'd9, 3'd3);
    finish_session(10'd8, 10'd7, 3'd0, 15);
    check("post_rst_ovr", 13'(bus.Overrun), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
